// File: rtl/prescaled_mod_counter.sv
// Modulo up/down counter with clock prescaler, clear, load, terminal count and wrap pulse.
// Define PRESCALED_MOD_COUNTER_SATURATE_EN to saturate at the boundary instead of wrapping.
module prescaled_mod_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULO   = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter_out,
  output logic             terminal_count,
  output logic             wrap
);

  // A single-bit prescaler is kept for PRESCALE=1; it stays at 0 and costs nothing.
  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 1);
  localparam logic [PreW-1:0]  PreMax = PreW'(PRESCALE - 1);

  logic [PreW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_bound;

  always_comb begin
    at_bound = up_down ? (cnt_q == MaxVal) : (cnt_q == '0);
  end

  always_comb begin
    cnt_d     = cnt_q;
    pre_cnt_d = pre_cnt_q;
    wrap_d    = 1'b0;
    if (clear) begin
      cnt_d     = '0;
      pre_cnt_d = '0;
    end else if (load) begin
      cnt_d     = (load_value > MaxVal) ? MaxVal : load_value;
      pre_cnt_d = '0;
    end else if (enable) begin
      if (pre_cnt_q == PreMax) begin
        pre_cnt_d = '0;
        if (at_bound) begin
`ifdef PRESCALED_MOD_COUNTER_SATURATE_EN
          cnt_d  = cnt_q;
`else
          cnt_d  = up_down ? '0 : MaxVal;
          wrap_d = 1'b1;
`endif
        end else begin
          cnt_d = up_down ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PreW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pre_cnt_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pre_cnt_q <= pre_cnt_d;
      wrap_q    <= wrap_d;
    end
  end

  assign counter_out    = cnt_q;
  assign terminal_count = at_bound;
  assign wrap           = wrap_q;

endmodule

// File: tb/tb_prescaled_mod_counter.sv
// Directed bench for prescaled_mod_counter: three instances cover the default,
// MODULO=10 and PRESCALE=3 configurations; saturate checks follow the build macro.
module tb_prescaled_mod_counter;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Instance a: WIDTH=4, MODULO=16, PRESCALE=1
  logic       en_a, ud_a, clr_a, ld_a, tc_a, wr_a;
  logic [3:0] lv_a, cnt_a;
  // Instance b: WIDTH=4, MODULO=10, PRESCALE=1
  logic       en_b, ud_b, clr_b, ld_b, tc_b, wr_b;
  logic [3:0] lv_b, cnt_b;
  // Instance c: WIDTH=4, MODULO=16, PRESCALE=3
  logic       en_c, ud_c, clr_c, ld_c, tc_c, wr_c;
  logic [3:0] lv_c, cnt_c;

  prescaled_mod_counter #(.WIDTH(4), .MODULO(16), .PRESCALE(1)) u_a (
    .clock(clock), .reset(reset), .enable(en_a), .up_down(ud_a), .clear(clr_a),
    .load(ld_a), .load_value(lv_a), .counter_out(cnt_a), .terminal_count(tc_a), .wrap(wr_a)
  );
  prescaled_mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u_b (
    .clock(clock), .reset(reset), .enable(en_b), .up_down(ud_b), .clear(clr_b),
    .load(ld_b), .load_value(lv_b), .counter_out(cnt_b), .terminal_count(tc_b), .wrap(wr_b)
  );
  prescaled_mod_counter #(.WIDTH(4), .MODULO(16), .PRESCALE(3)) u_c (
    .clock(clock), .reset(reset), .enable(en_c), .up_down(ud_c), .clear(clr_c),
    .load(ld_c), .load_value(lv_c), .counter_out(cnt_c), .terminal_count(tc_c), .wrap(wr_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef PRESCALED_MOD_COUNTER_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    {en_a, ud_a, clr_a, ld_a} = '0; lv_a = '0;
    {en_b, ud_b, clr_b, ld_b} = '0; lv_b = '0;
    {en_c, ud_c, clr_c, ld_c} = '0; lv_c = '0;
    tick(); tick();
    n_checks++;
    if (cnt_a !== 4'd0 || wr_a !== 1'b0 || tc_a !== 1'b1) begin
      $display("FAIL reset_a: cnt=%0d wrap=%b tc=%b, required cnt=0 wrap=0 tc=1", cnt_a, wr_a, tc_a);
      n_fail++;
    end
    n_checks++;
    if (cnt_b !== 4'd0 || cnt_c !== 4'd0 || wr_b !== 1'b0 || wr_c !== 1'b0) begin
      $display("FAIL reset_bc: cnt_b=%0d cnt_c=%0d wrap_b=%b wrap_c=%b, required all 0",
               cnt_b, cnt_c, wr_b, wr_c);
      n_fail++;
    end
    ud_a = 1'b1;
    #1;
    n_checks++;
    if (tc_a !== 1'b0) begin
      $display("FAIL tc_direction: tc=%b, required 0", tc_a);
      n_fail++;
    end
    reset = 1'b1;
  endtask

  task automatic test_count_up();
    int exp_cnt;
    en_a = 1'b1; ud_a = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_cnt = Sat ? ((i > 15) ? 15 : i) : (i % 16);
      n_checks++;
      if (cnt_a !== 4'(exp_cnt) || wr_a !== (!Sat && i == 16) || tc_a !== (exp_cnt == 15)) begin
        $display("FAIL count_up[%0d]: cnt=%0d wrap=%b tc=%b, required cnt=%0d wrap=%b tc=%b",
                 i, cnt_a, wr_a, tc_a, exp_cnt, (!Sat && i == 16), (exp_cnt == 15));
        n_fail++;
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_modulo_down();
    int exp_seq [4];
    bit exp_wr  [4];
    ld_b = 1'b1; lv_b = 4'd2; ud_b = 1'b0;
    tick();
    ld_b = 1'b0;
    n_checks++;
    if (cnt_b !== 4'd2) begin
      $display("FAIL load2: cnt=%0d, required 2", cnt_b);
      n_fail++;
    end
    exp_seq = Sat ? '{1, 0, 0, 0} : '{1, 0, 9, 8};
    exp_wr  = Sat ? '{0, 0, 0, 0} : '{0, 0, 1, 0};
    en_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (cnt_b !== 4'(exp_seq[i]) || wr_b !== exp_wr[i] || tc_b !== (exp_seq[i] == 0)) begin
        $display("FAIL down_mod10[%0d]: cnt=%0d wrap=%b tc=%b, required cnt=%0d wrap=%b tc=%b",
                 i, cnt_b, wr_b, tc_b, exp_seq[i], exp_wr[i], (exp_seq[i] == 0));
        n_fail++;
      end
    end
    en_b = 1'b0; ld_b = 1'b1; lv_b = 4'd13;
    tick();
    ld_b = 1'b0;
    n_checks++;
    if (cnt_b !== 4'd9 || wr_b !== 1'b0) begin
      $display("FAIL load_clamp: cnt=%0d wrap=%b, required cnt=9 wrap=0", cnt_b, wr_b);
      n_fail++;
    end
    // Up step from MODULO-1 of a non power-of-two modulus
    ud_b = 1'b1; en_b = 1'b1;
    tick();
    en_b = 1'b0;
    n_checks++;
    if (cnt_b !== (Sat ? 4'd9 : 4'd0) || wr_b !== !Sat) begin
      $display("FAIL up_wrap_mod10: cnt=%0d wrap=%b, required cnt=%0d wrap=%b",
               cnt_b, wr_b, (Sat ? 9 : 0), !Sat);
      n_fail++;
    end
  endtask

  task automatic test_prescale();
    en_c = 1'b1; ud_c = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++;
      if (cnt_c !== 4'(k / 3)) begin
        $display("FAIL prescale[%0d]: cnt=%0d, required %0d", k, cnt_c, k / 3);
        n_fail++;
      end
    end
    tick();
    en_c = 1'b0;
    tick(); tick();
    n_checks++;
    if (cnt_c !== 4'd3) begin
      $display("FAIL prescale_hold: cnt=%0d, required 3", cnt_c);
      n_fail++;
    end
    en_c = 1'b1;
    tick();
    n_checks++;
    if (cnt_c !== 4'd3) begin
      $display("FAIL prescale_phase_a: cnt=%0d, required 3", cnt_c);
      n_fail++;
    end
    tick();
    en_c = 1'b0;
    n_checks++;
    if (cnt_c !== 4'd4) begin
      $display("FAIL prescale_phase_b: cnt=%0d, required 4", cnt_c);
      n_fail++;
    end
  endtask

  task automatic test_priority();
    ld_a = 1'b1; lv_a = 4'd7;
    tick();
    clr_a = 1'b1; lv_a = 4'd5;
    tick();
    clr_a = 1'b0;
    n_checks++;
    if (cnt_a !== 4'd0) begin
      $display("FAIL clear_over_load: cnt=%0d, required 0", cnt_a);
      n_fail++;
    end
    lv_a = 4'd7;
    tick();
    en_a = 1'b1; ud_a = 1'b1; lv_a = 4'd5;
    tick();
    n_checks++;
    if (cnt_a !== 4'd5 || wr_a !== 1'b0) begin
      $display("FAIL load_over_step: cnt=%0d wrap=%b, required cnt=5 wrap=0", cnt_a, wr_a);
      n_fail++;
    end
    // Pending step would wrap from 15; load must still win without a wrap pulse
    en_a = 1'b0; lv_a = 4'd15;
    tick();
    en_a = 1'b1; lv_a = 4'd5;
    tick();
    n_checks++;
    if (cnt_a !== 4'd5 || wr_a !== 1'b0) begin
      $display("FAIL load_over_wrap: cnt=%0d wrap=%b, required cnt=5 wrap=0", cnt_a, wr_a);
      n_fail++;
    end
    ld_a = 1'b0; clr_a = 1'b1;
    tick();
    clr_a = 1'b0; en_a = 1'b0;
    n_checks++;
    if (cnt_a !== 4'd0) begin
      $display("FAIL clear_over_enable: cnt=%0d, required 0", cnt_a);
      n_fail++;
    end
  endtask

  task automatic test_async_reset();
    ld_a = 1'b1; lv_a = 4'd11;
    tick();
    ld_a = 1'b0;
    n_checks++;
    if (cnt_a !== 4'd11) begin
      $display("FAIL load11: cnt=%0d, required 11", cnt_a);
      n_fail++;
    end
    en_a = 1'b1; ud_a = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (cnt_a !== 4'd0 || wr_a !== 1'b0) begin
      $display("FAIL async_reset: cnt=%0d wrap=%b, required cnt=0 wrap=0", cnt_a, wr_a);
      n_fail++;
    end
    tick();
    reset = 1'b1;
    tick();
    en_a = 1'b0;
    n_checks++;
    if (cnt_a !== 4'd1) begin
      $display("FAIL resume_after_reset: cnt=%0d, required 1", cnt_a);
      n_fail++;
    end
  endtask

  task automatic test_saturate();
    int exp_up [4];
    int exp_dn [3];
    exp_up = Sat ? '{15, 15, 15, 15} : '{15, 0, 1, 2};
    exp_dn = Sat ? '{0, 0, 0} : '{0, 15, 14};
    ld_a = 1'b1; lv_a = 4'd14;
    tick();
    ld_a = 1'b0; en_a = 1'b1; ud_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (cnt_a !== 4'(exp_up[i]) || wr_a !== (!Sat && i == 1)) begin
        $display("FAIL boundary_up[%0d]: cnt=%0d wrap=%b, required cnt=%0d wrap=%b",
                 i, cnt_a, wr_a, exp_up[i], (!Sat && i == 1));
        n_fail++;
      end
    end
    en_a = 1'b0; ld_a = 1'b1; lv_a = 4'd1;
    tick();
    ld_a = 1'b0; en_a = 1'b1; ud_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (cnt_a !== 4'(exp_dn[i]) || wr_a !== (!Sat && i == 1)) begin
        $display("FAIL boundary_down[%0d]: cnt=%0d wrap=%b, required cnt=%0d wrap=%b",
                 i, cnt_a, wr_a, exp_dn[i], (!Sat && i == 1));
        n_fail++;
      end
    end
    en_a = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_count_up();
    test_modulo_down();
    test_prescale();
    test_priority();
    test_async_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prescaled_mod_counter.md
# prescaled_mod_counter

Parametrised successor to the team's 4-bit enable counter. It adds configurable width, modulus and clock prescale, up/down direction, synchronous clear and parallel load, a terminal-count flag and a wrap pulse. It is used as a general event/tick counter and timer in datapath and control blocks. An optional build mode replaces wrap-around with saturation.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `MODULO`, default 16: count range is 0..MODULO-1. Legal range is 2 ≤ MODULO ≤ 2^WIDTH.
- `PRESCALE`, default 1: number of enabled cycles per count step. Must be ≥ 1; 1 means a step every enabled cycle.
- `clock`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset. Asserting (low) clears all state immediately; deassertion is synchronised externally.
- `enable`  input  1  advances the prescaler and the counter when high.
- `up_down`  input  1  direction: 1 counts up, 0 counts down.
- `clear`  input  1  synchronous clear of counter and prescaler.
- `load`  input  1  synchronous parallel load.
- `load_value`  input  WIDTH  value written on `load`.
- `counter_out`  output  WIDTH  current count, registered.
- `terminal_count`  output  1  combinational. High when `counter_out` == MODULO-1 with `up_down`=1, or when `counter_out` == 0 with `up_down`=0.
- `wrap`  output  1  registered, one-cycle pulse marking a wrap-around step.

## Operation
- Internal prescaler `pre_cnt`, range 0..PRESCALE-1. The counter is never wider than required.
- Per-edge priority: clear > load > enable > hold.
  - `clear`: `counter_out`=0, `pre_cnt`=0, `wrap`=0.
  - `load`: `counter_out` = min(`load_value`, MODULO-1), `pre_cnt`=0, `wrap`=0.
  - `enable`:
    - If `pre_cnt` == PRESCALE-1, take a step and set `pre_cnt`=0.
    - Otherwise increment `pre_cnt`; there is no step and `wrap`=0.
  - `enable` low: counter and `pre_cnt` hold; `wrap`=0.
- Step, up direction: if `counter_out` == MODULO-1, the next value is 0 and `wrap`=1. Otherwise the next value is `counter_out`+1 and `wrap`=0.
- Step, down direction: if `counter_out` == 0, the next value is MODULO-1 and `wrap`=1. Otherwise the next value is `counter_out`-1 and `wrap`=0.
- Arithmetic is unsigned. The comparison against MODULO-1 is done in WIDTH bits. When MODULO = 2^WIDTH, natural overflow and the explicit wrap give identical results.
- A change of `up_down` takes effect on the next step. `pre_cnt` is not disturbed.

## Timing
- Reset (`reset` low, asynchronous): `counter_out`=0, `pre_cnt`=0, `wrap`=0. `terminal_count` then follows the combinational rule; it is 1 if `up_down`=0.
- Latency: a step is visible on `counter_out` one edge after the enabled cycle in which `pre_cnt` == PRESCALE-1.
- `wrap` is high for exactly the one cycle following the edge that produced the wrapped value.
- `terminal_count` responds to `up_down` within the same cycle, with no register delay.
- `clear` and `load` asserted together: clear wins.
- `load` asserted together with a pending step: load wins, and the step is discarded (no `wrap`).
- Reset asserted mid-count: the state clears immediately, independent of `clock`. Counting resumes from 0 at the first enabled edge after release.

## Configuration
- Macro `PRESCALED_MOD_COUNTER_SATURATE_EN`.
- Defined: a step at the boundary leaves `counter_out` unchanged. This covers MODULO-1 when counting up and 0 when counting down. `wrap` is tied to 0, and all other behaviour is unchanged.
- Undefined (default): wrap-around behaviour as described in Operation.

## Test plan
- Reset and count, with WIDTH=4, MODULO=16, PRESCALE=1. Hold `reset` low, release, set `enable`=1 and `up_down`=1 for 20 cycles.
  - Expected: `counter_out` goes 0,1,…,15,0,1,2,3.
  - Expected: `wrap` is high only in the cycle after the value becomes 0, and `terminal_count` is high while the value is 15.
- Modulus and down count, with WIDTH=4, MODULO=10. Load 2, then count down for 4 steps.
  - Expected: `counter_out` goes 2,1,0,9,8, with `wrap` pulsing when the value becomes 9.
  - Load 13: `counter_out`=9 (clamped).
- Prescale, with PRESCALE=3 and `enable` held high for 9 cycles.
  - Expected: `counter_out` goes 0→1→2→3, with one step every third cycle.
  - Drop `enable` for 2 cycles mid-period: no step occurs, and the phase resumes afterwards.
- Priority, starting at `counter_out`=7.
  - Same edge `clear`=1, `load`=1, `load_value`=5: result 0.
  - `load`=1 with `load_value`=5 and a pending step: result 5, `wrap`=0.
- Asynchronous reset: at count 11, pull `reset` low between clock edges.
  - Expected: `counter_out`=0 before the next rising edge; `wrap`=0.
- Saturate build, with `PRESCALED_MOD_COUNTER_SATURATE_EN` defined and MODULO=16.
  - Count up from 14 for 4 steps: output 15,15,15,15.
  - Count down from 1 for 3 steps: output 0,0,0.
  - `wrap` stays 0 throughout.
